spi_master_dx: RTL and testbench

Parametrised, full-duplex successor to the fixed 8-bit TX-only SPI master. It shifts a DATA_W-bit word out on MOSI while capturing DATA_W bits from MISO. SPI mode (CPOL/CPHA) is selectable per transfer, and SCLK is generated from i_clock by a programmable divider. It drives an active-low chip select and reports completion with a one-cycle o_done pulse. It sits between a message source (register file/FIFO) and the off-chip SPI slave.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_clk_gen.sv | 53 +++++
 rtl/spi_master_dx.sv | 170 +++++++++++++++++
 tb/tb_spi_master_dx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the spi_master_dx block.
//   spi_state_t : transfer FSM states (IDLE -> LEAD -> XFER -> TRAIL -> DONE)
//   spi_mode_t  : SPI mode as {cpol, cpha}; bit order matches the i_mode port
//   SPI_MODE0-3 : the four standard SPI modes
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL,
    DONE
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timebase for spi_master_dx.
// Counts CLK_DIV i_clock cycles per SCLK half-period while enabled and emits a
// one-cycle tick on the last cycle of each half-period.
//   i_clock   : system clock
//   i_reset   : asynchronous, active-high reset
//   i_en      : count enable
//   i_clr     : synchronous clear of the counter and edge phase
//   i_edge_en : ticks toggle the SCLK phase only while this is high
//   o_tick    : half-period boundary pulse
//   o_lead    : with o_tick, high when this boundary is a leading SCLK edge
//   o_half    : current SCLK phase (0 = idle level, 1 = active level)
module spi_clk_gen #(
  parameter int CLK_DIV = 2,
  parameter int CNT_W   = $clog2(CLK_DIV + 1)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_edge_en,
  output logic o_tick,
  output logic o_lead,
  output logic o_half
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_half;
  logic             w_tick;

  assign w_tick = i_en && (r_cnt == LastCnt);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else if (i_en) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick && i_edge_en) begin
        r_half <= ~r_half;
      end
    end
  end

  assign o_tick = w_tick;
  assign o_lead = ~r_half;
  assign o_half = r_half;

endmodule

// File: rtl/spi_master_dx.sv
// Full-duplex SPI master with per-transfer mode and programmable SCLK divider.
// Shifts DATA_W bits out on o_mosi while capturing DATA_W bits from i_miso.
// Optional build macro SPI_LSB_FIRST_EN adds i_lsb_first (LSB-first transfers).
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_send           : start request, accepted only in IDLE
//   i_data, i_mode   : TX word and {CPOL,CPHA}, latched on accept
//   i_miso           : serial input from slave (sampled directly, SCLK-timed)
//   o_sclk, o_mosi   : SPI clock and serial output
//   o_cs_n           : active-low chip select
//   o_busy, o_done   : transfer in progress / one-cycle completion pulse
//   o_rx_data        : received word, updated with o_done
module spi_master_dx
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_send,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_mode,
  input  logic              i_miso,
`ifdef SPI_LSB_FIRST_EN
  input  logic              i_lsb_first,
`endif
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_cs_n,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data
);

  localparam int CNT_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LastEdge = EDGE_W'(2 * DATA_W - 1);

  spi_state_t        r_state, w_state_next;
  spi_mode_t         r_mode, w_mode_in;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic [EDGE_W-1:0] r_edge;
  logic              r_mosi, r_cs_n, r_busy, r_done;
  logic              w_accept, w_busy_next, w_done_next;
  logic              w_tick, w_lead, w_half, w_shift_now;
  logic              w_lsb_in, w_lsb;

  assign w_mode_in = spi_mode_t'(i_mode);

`ifdef SPI_LSB_FIRST_EN
  logic r_lsb;
  assign w_lsb_in = i_lsb_first;
  assign w_lsb    = r_lsb;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_lsb <= 1'b0;
    end else if (w_accept) begin
      r_lsb <= i_lsb_first;
    end
  end
`else
  assign w_lsb_in = 1'b0;
  assign w_lsb    = 1'b0;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_clk_gen (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_en      (r_busy),
    .i_clr     (w_accept),
    .i_edge_en (r_state == XFER),
    .o_tick    (w_tick),
    .o_lead    (w_lead),
    .o_half    (w_half)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_send) begin
          w_accept     = 1'b1;
          w_state_next = LEAD;
        end
      end
      LEAD:    if (w_tick) w_state_next = XFER;
      XFER:    if (w_tick && (r_edge == LastEdge)) w_state_next = TRAIL;
      TRAIL:   if (w_tick) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    w_busy_next = (w_state_next == LEAD) || (w_state_next == XFER) || (w_state_next == TRAIL);
    w_done_next = (w_state_next == DONE);
  end

  // CPHA=0 shifts on trailing edges, CPHA=1 on leading; the other edge samples.
  assign w_shift_now = (w_lead == r_mode.cpha);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_mode    <= SPI_MODE0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_edge    <= '0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // Control outputs are registered from the next state so they never glitch.
      r_cs_n <= ~w_busy_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      if (w_accept) begin
        r_mode <= w_mode_in;
        r_rx   <= '0;
        r_edge <= '0;
        if (!w_mode_in.cpha) begin
          r_mosi <= first_bit(i_data, w_lsb_in);
          r_tx   <= shift_out(i_data, w_lsb_in);
        end else begin
          r_mosi <= 1'b0;
          r_tx   <= i_data;
        end
      end else if ((r_state == XFER) && w_tick) begin
        r_edge <= r_edge + 1'b1;
        if (w_shift_now) begin
          r_mosi <= first_bit(r_tx, w_lsb);
          r_tx   <= shift_out(r_tx, w_lsb);
        end else if (w_lsb) begin
          r_rx <= {i_miso, r_rx[DATA_W-1:1]};
        end else begin
          r_rx <= {r_rx[DATA_W-2:0], i_miso};
        end
      end else if ((r_state == TRAIL) && w_tick) begin
        r_rx_data <= r_rx;
        r_mosi    <= 1'b0;
      end
    end
  end

  assign o_sclk    = r_mode.cpol ^ w_half;
  assign o_mosi    = r_mosi;
  assign o_cs_n    = r_cs_n;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master_dx.sv
// Scoreboard bench for spi_master_dx (DATA_W=8, CLK_DIV=2).
module tb_spi_master_dx;
  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 2;
  localparam int LAT     = (2 * DATA_W + 2) * CLK_DIV + 1;
  localparam int CS_LOW  = (2 * DATA_W + 2) * CLK_DIV;

  typedef struct {
    logic [DATA_W-1:0] rx;
    int unsigned       cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              send = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic [1:0]        mode = 2'b00;
  logic              miso_w;
  logic              sclk, mosi, cs_n, busy, done;
  logic [DATA_W-1:0] rx;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first = 1'b0;
`endif

  bit                tb_loop = 1'b0;
  bit                tb_slave = 1'b0;
  logic              tb_miso_const = 1'b0;
  logic              slv_miso = 1'b0;
  logic [DATA_W-1:0] slv_tx = '0;
  logic [DATA_W-1:0] slv_rx = '0;
  logic [DATA_W-1:0] slv_last = '0;
  int                slv_idx = DATA_W - 1;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  exp_t        sb_q[$];
  exp_t        sb_e;
  int          done_total = 0, cs_low_total = 0, busy_total = 0, rise_total = 0;
  int          mosi_nz_total = 0, mosi_bad_total = 0;
  logic        prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_mosi = 1'b0;

  assign miso_w = tb_loop ? mosi : (tb_slave ? slv_miso : tb_miso_const);

  spi_master_dx #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_send      (send),
    .i_data      (data),
    .i_mode      (mode),
    .i_miso      (miso_w),
`ifdef SPI_LSB_FIRST_EN
    .i_lsb_first (lsb_first),
`endif
    .o_sclk      (sclk),
    .o_mosi      (mosi),
    .o_cs_n      (cs_n),
    .o_busy      (busy),
    .o_done      (done),
    .o_rx_data   (rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pop on o_done, plus bus statistics and a simple slave.
  always @(negedge clk) begin
    if (done) begin
      done_total++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: o_done at cycle %0d, got rx 0x%0h, required none", cyc, rx);
      end else begin
        sb_e = sb_q.pop_front();
        chk("rx_data", rx, sb_e.rx);
        chk("done_cycle", cyc, sb_e.cyc);
      end
    end
    if (!cs_n) cs_low_total++;
    if (busy) busy_total++;
    if (!cs_n && mosi) mosi_nz_total++;
    if (!cs_n && sclk && !prev_sclk) begin
      rise_total++;
      slv_rx = {slv_rx[DATA_W-2:0], mosi};
    end
    if (!cs_n && !prev_cs_n && (mosi !== prev_mosi) && !(prev_sclk && !sclk)) mosi_bad_total++;
    if (!cs_n && !sclk && prev_sclk && (slv_idx >= 0)) begin
      slv_miso = slv_tx[slv_idx];
      slv_idx--;
    end
    if (cs_n) begin
      if (!prev_cs_n) slv_last = slv_rx;
      slv_rx  = '0;
      slv_idx = DATA_W - 1;
    end
    prev_sclk = sclk;
    prev_cs_n = cs_n;
    prev_mosi = mosi;
  end

  // Request one transfer; returns #1 after the first LEAD edge.
  task automatic start(input logic [DATA_W-1:0] d, input logic [1:0] m,
                       input logic [DATA_W-1:0] exp_rx, input bit push);
    @(posedge clk);
    #1;
    data = d;
    mode = m;
    send = 1'b1;
    if (push) sb_q.push_back('{rx: exp_rx, cyc: cyc + LAT});
    @(posedge clk);
    #1;
    send = 1'b0;
    data = ~d;  // must not disturb the transfer in flight
    mode = ~m;
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while ((sb_q.size() != 0) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", sb_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_rise, s_cs, s_busy, s_done, s_nz, s_bad;
    int unsigned k;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cs_n", cs_n, 1);
    chk("reset_sclk", sclk, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rx", rx, 0);

    // Mode 0 loopback 0xA5
    tb_loop = 1'b1;
    s_rise = rise_total; s_cs = cs_low_total; s_busy = busy_total;
    start(8'hA5, 2'b00, 8'hA5, 1'b1);
    chk("m0_first_mosi", mosi, 1);
    chk("m0_lead_cs_n", cs_n, 0);
    chk("m0_lead_sclk", sclk, 0);
    wait_sb(100);
    chk("m0_sclk_rises", rise_total - s_rise, DATA_W);
    chk("m0_cs_low_cycles", cs_low_total - s_cs, CS_LOW);
    chk("m0_busy_cycles", busy_total - s_busy, CS_LOW);
    chk("m0_slave_saw", slv_last, 8'hA5);

    // Mode 3, slave returns 0xC3
    tb_loop = 1'b0; tb_slave = 1'b1; slv_tx = 8'hC3;
    s_bad = mosi_bad_total;
    start(8'h3C, 2'b11, 8'hC3, 1'b1);
    chk("m3_lead_sclk_high", sclk, 1);
    chk("m3_lead_busy", busy, 1);
    wait_sb(100);
    chk("m3_idle_sclk_high", sclk, 1);
    chk("m3_mosi_on_falling_only", mosi_bad_total - s_bad, 0);
    chk("m3_slave_saw", slv_last, 8'h3C);

    // Mode 1, MISO tied high, TX zeros
    tb_slave = 1'b0; tb_miso_const = 1'b1;
    s_nz = mosi_nz_total; s_done = done_total;
    start(8'h00, 2'b01, 8'hFF, 1'b1);
    wait_sb(100);
    repeat (20) @(posedge clk);
    chk("m1_mosi_zero", mosi_nz_total - s_nz, 0);
    chk("m1_one_done", done_total - s_done, 1);

    // i_send held 60 cycles: two transfers, second accepted right after DONE
    tb_loop = 1'b1; tb_miso_const = 1'b0;
    s_done = done_total;
    @(posedge clk);
    #1;
    k = cyc;
    data = 8'h5A; mode = 2'b00; send = 1'b1;
    sb_q.push_back('{rx: 8'h5A, cyc: k + LAT});
    sb_q.push_back('{rx: 8'h5A, cyc: k + 2 * LAT + 1});
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      // cs_n is high in DONE and in the accepting IDLE cycle, low from LEAD on
      if (cyc == k + LAT) chk("b2b_done_cs_n", cs_n, 1);
      if (cyc == k + LAT + 1) chk("b2b_gap_busy", busy, 0);
      if (cyc == k + LAT + 2) begin
        chk("b2b_lead2_cs_n", cs_n, 0);
        chk("b2b_lead2_busy", busy, 1);
      end
    end
    @(posedge clk);
    #1;
    send = 1'b0;
    wait_sb(150);
    repeat (40) @(posedge clk);
    chk("b2b_done_count", done_total - s_done, 2);

    // Asynchronous reset in the middle of a mode 3 transfer
    s_done = done_total;
    start(8'hFF, 2'b11, 8'h00, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    chk("rst_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rx", rx, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    chk("rst_no_done", done_total - s_done, 0);

    // Recovery: mode 2 loopback
    start(8'h96, 2'b10, 8'h96, 1'b1);
    wait_sb(100);

`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b1;
    start(8'h01, 2'b00, 8'h01, 1'b1);
    lsb_first = 1'b0;
    chk("lsb_first_mosi", mosi, 1);
    wait_sb(100);
`endif

    chk("final_queue_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
